// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a counter-based bit timer.
// The line is double-flopped before use. Bits are sampled at mid-bit,
// measured from the synchronized falling edge of the start bit.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | line idle, waiting for synchronized low
//   ST_START | timing half a bit to re-check the start bit
//   ST_DATA  | sampling 8 data bits, LSB first, one per bit period
//   ST_STOP  | sampling the stop bit; good byte or framing error
//   ST_BREAK | stop bit was low; wait for the line to go high again
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_RX_Bit,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_Frame_Err,
    output logic       o_Busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic        err_q, err_d;
    logic [1:0]  sync_q;
    logic        s;

    assign s = sync_q[1];

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_RX_Bit};
        end
    end

    // State, timer, shift register and registered output pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by the bit counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    // A high line at mid-start is a glitch, not a frame.
                    state_d = s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    sh_d[idx_q] = s;
                    cnt_d       = '0;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (s) begin
                        byte_d  = sh_q;
                        dv_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (s) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign o_RX_Byte   = byte_q;
    assign o_RX_DV     = dv_q;
    assign o_Frame_Err = err_q;
    assign o_Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus randomized frames, checked
// against an event-level model (expected pulse kind, byte and time per frame).
module tb_uart_rx;

    localparam int  C   = 16;
    localparam time PER = 10;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        time        t;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_good;
    int         n_checks;
    int         n_errors;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_RX_Bit    (rx),
        .o_RX_Byte   (rx_byte),
        .o_RX_DV     (rx_dv),
        .o_Frame_Err (frame_err),
        .o_Busy      (busy)
    );

    initial clk = 1'b0;
    always #(PER / 2) clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Record every output pulse seen between clock edges.
    always @(negedge clk) begin
        if (rx_dv || frame_err) begin
            chk("dv_err_excl", longint'(rx_dv && frame_err), 0);
            mon_e.is_err = frame_err;
            mon_e.data   = rx_byte;
            mon_e.t      = $time;
            obs_q.push_back(mon_e);
        end
    end

    // Drives one 8N1 frame from a negedge; predicts the resulting pulse.
    // The stop sample is C/2+2+9C edges after the first edge that sees the
    // start bit, and the pulse is visible one cycle later.
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        logic [9:0] bits;
        ev_t        e;
        time        t0;
        bits = {stop_b, d, 1'b0};
        t0   = $time;
        e.t  = t0 + time'(C / 2 + 3 + 9 * C) * PER;
        if (stop_b) begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_events(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_kind"}, obs_q[i].is_err, exp_q[i].is_err);
            chk({tag, "_byte"}, obs_q[i].data, exp_q[i].data);
            chk({tag, "_time"}, longint'(obs_q[i].t), longint'(exp_q[i].t));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_good = 8'h00;
        rx        = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_byte", rx_byte, 8'h00);
        chk("rst_dv", rx_dv, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Idle line
        idle(500);
        chk("idle_busy", busy, 0);
        chk("idle_byte", rx_byte, 8'h00);
        compare_events("idle");

        // Single good frame
        send_frame(8'hA5, 1'b1);
        idle(20);
        chk("a5_hold", rx_byte, 8'hA5);
        chk("a5_busy", busy, 0);
        compare_events("a5");

        // Short low glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        repeat (C / 2 + 3 - 6) @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        idle(20);
        compare_events("glitch");

        // Bad stop bit, held-low line, then recovery
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        chk("break_busy", busy, 1);
        chk("break_byte", rx_byte, 8'hA5);
        idle(4);
        chk("break_exit", busy, 0);
        send_frame(8'h7E, 1'b1);
        idle(20);
        compare_events("ferr");

        // Asynchronous reset in the middle of data bit 3
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            repeat (C) @(negedge clk);
        end
        rx = 1'b1;
        repeat (C / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_byte", rx_byte, 8'h00);
        chk("arst_busy", busy, 0);
        chk("arst_dv", rx_dv, 0);
        chk("arst_err", frame_err, 0);
        last_good = 8'h00;
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(5);
        send_frame(8'h5A, 1'b1);
        idle(20);
        compare_events("arst");

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        if (obs_q.size() == 2)
            chk("b2b_spacing", longint'(obs_q[1].t - obs_q[0].t), longint'(160 * PER));
        compare_events("b2b");

        // Randomized traffic: good frames, framing errors, glitches
        for (int n = 0; n < 30; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                rx = 1'b0;
                repeat ($urandom_range(1, C / 2 - 2)) @(negedge clk);
                idle(C);
            end else if (r == 2) begin
                send_frame(8'($urandom), 1'b0);
                repeat ($urandom_range(0, 20)) @(negedge clk);
                idle($urandom_range(2, 6));
            end else begin
                send_frame(8'($urandom), 1'b1);
                idle($urandom_range(0, 3));
            end
        end
        idle(30);
        chk("rand_busy", busy, 0);
        compare_events("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
